// File: rtl/morse_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_stream_decoder
// Description : Decodes a 2-bit Morse symbol stream into character codes
//               (A-Z, 0-9, word space, error) and buffers them in a small
//               FIFO with a valid/ack handshake toward the display side.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_stream_decoder #(
    parameter int MAX_LEN    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] serial_in,
    input  logic       update,
    output logic       in_ready,
    output logic [5:0] char_out,
    output logic       char_valid,
    input  logic       char_ack,
    output logic       overrun
);

    localparam int         c_LEN_W      = $clog2(MAX_LEN + 1);
    localparam int         c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [5:0] c_CODE_SPACE = 6'd37;
    localparam logic [5:0] c_CODE_ERR   = 6'd63;

    // Character accumulator and word-space tracking
    logic [c_LEN_W-1:0] r_len;
    logic [MAX_LEN-1:0] r_pattern;
    logic               r_ovf;
    logic               r_space_pend;
    logic               r_char_since_space;
    logic               r_overrun;

    // Output FIFO
    logic [5:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_accept;
    logic       w_has_elem;
    logic       w_push_char;
    logic       w_push_space;
    logic       w_push;
    logic       w_pop;
    logic [5:0] w_code;
    logic [5:0] w_push_data;

    assign w_full       = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_accept     = update & in_ready;
    assign w_has_elem   = (r_len != '0);
    // Both space kinds (11 and 10) close a pending character
    assign w_push_char  = w_accept & serial_in[1] & w_has_elem;
    // Space push never collides with a character push: in_ready is low while pending
    assign w_push_space = r_space_pend & ~w_full;
    assign w_push       = w_push_char | w_push_space;
    assign w_push_data  = w_push_space ? c_CODE_SPACE : w_code;
    assign w_pop        = char_ack & ~w_empty;

    assign in_ready   = ~w_full & ~r_space_pend;
    assign char_valid = ~w_empty;
    assign char_out   = w_empty ? 6'd0 : r_mem[r_rd_ptr];
    assign overrun    = r_overrun;

    // Pattern lookup: low r_len bits of r_pattern, first element in the MSB
    always_comb begin
        w_code = c_CODE_ERR;
        if (!r_ovf && (r_len <= c_LEN_W'(5))) begin
            case (r_len)
                c_LEN_W'(1): w_code = r_pattern[0] ? 6'd20 : 6'd5;
                c_LEN_W'(2): begin
                    case (r_pattern[1:0])
                        2'b00: w_code = 6'd9;   // I
                        2'b01: w_code = 6'd1;   // A
                        2'b10: w_code = 6'd14;  // N
                        2'b11: w_code = 6'd13;  // M
                    endcase
                end
                c_LEN_W'(3): begin
                    case (r_pattern[2:0])
                        3'b000: w_code = 6'd19; // S
                        3'b001: w_code = 6'd21; // U
                        3'b010: w_code = 6'd18; // R
                        3'b011: w_code = 6'd23; // W
                        3'b100: w_code = 6'd4;  // D
                        3'b101: w_code = 6'd11; // K
                        3'b110: w_code = 6'd7;  // G
                        3'b111: w_code = 6'd15; // O
                    endcase
                end
                c_LEN_W'(4): begin
                    case (r_pattern[3:0])
                        4'b0000: w_code = 6'd8;  // H
                        4'b0001: w_code = 6'd22; // V
                        4'b0010: w_code = 6'd6;  // F
                        4'b0100: w_code = 6'd12; // L
                        4'b0110: w_code = 6'd16; // P
                        4'b0111: w_code = 6'd10; // J
                        4'b1000: w_code = 6'd2;  // B
                        4'b1001: w_code = 6'd24; // X
                        4'b1010: w_code = 6'd3;  // C
                        4'b1011: w_code = 6'd25; // Y
                        4'b1100: w_code = 6'd26; // Z
                        4'b1101: w_code = 6'd17; // Q
                        default: w_code = c_CODE_ERR;
                    endcase
                end
                c_LEN_W'(5): begin
                    case (r_pattern[4:0])
                        5'b11111: w_code = 6'd27; // 0
                        5'b01111: w_code = 6'd28; // 1
                        5'b00111: w_code = 6'd29; // 2
                        5'b00011: w_code = 6'd30; // 3
                        5'b00001: w_code = 6'd31; // 4
                        5'b00000: w_code = 6'd32; // 5
                        5'b10000: w_code = 6'd33; // 6
                        5'b11000: w_code = 6'd34; // 7
                        5'b11100: w_code = 6'd35; // 8
                        5'b11110: w_code = 6'd36; // 9
                        default:  w_code = c_CODE_ERR;
                    endcase
                end
                default: w_code = c_CODE_ERR;
            endcase
        end
    end

    // Accumulate dots/dashes; any space symbol clears the character
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_pattern <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            if (!serial_in[1]) begin
                if (r_len < c_LEN_W'(MAX_LEN)) begin
                    r_pattern <= (r_pattern << 1) | {{(MAX_LEN-1){1'b0}}, serial_in[0]};
                    r_len     <= r_len + c_LEN_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_len     <= '0;
                r_pattern <= '0;
                r_ovf     <= 1'b0;
            end
        end
    end

    // Word-space request: only after a real character since the previous space
    always_ff @(posedge clk) begin
        if (rst) begin
            r_space_pend       <= 1'b0;
            r_char_since_space <= 1'b0;
        end else begin
            if (w_push_space) begin
                r_space_pend <= 1'b0;
            end
            if (w_accept && serial_in[1]) begin
                if (!serial_in[0]) begin
                    if (r_char_since_space || w_has_elem) begin
                        r_space_pend       <= 1'b1;
                        r_char_since_space <= 1'b0;
                    end
                end else if (w_has_elem) begin
                    r_char_since_space <= 1'b1;
                end
            end
        end
    end

    // Sticky flag for updates offered while the block was not ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (update && !in_ready) begin
            r_overrun <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_stream_decoder
// Description : Directed scoreboard bench for morse_stream_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_stream_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] serial_in;
    logic       update;
    logic       in_ready;
    logic [5:0] char_out;
    logic       char_valid;
    logic       char_ack;
    logic       overrun;

    int         n_pass  = 0;
    int         n_total = 0;
    int         exp_q[$];

    morse_stream_decoder #(.MAX_LEN(5), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .update     (update),
        .in_ready   (in_ready),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ack   (char_ack),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Monitor: every accepted output (valid & ack) is compared to the queue head
    always @(negedge clk) begin
        if (char_valid && char_ack) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got %0d, expected nothing", char_out);
            end else begin
                check("scoreboard_code", int'(char_out), exp_q.pop_front());
            end
        end
    end

    task automatic sym(input logic [1:0] s);
        update = 1'b1; serial_in = s;
        @(posedge clk); #1;
        update = 1'b0; serial_in = 2'b00;
    endtask

    task automatic sym_ack(input logic [1:0] s);
        update = 1'b1; serial_in = s; char_ack = 1'b1;
        @(posedge clk); #1;
        update = 1'b0; serial_in = 2'b00; char_ack = 1'b0;
    endtask

    task automatic pattern(input string p);
        for (int i = 0; i < p.len(); i++) begin
            byte c;
            c = p[i];
            sym((c == 8'h2D) ? 2'b01 : 2'b00);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic ack_one();
        char_ack = 1'b1;
        @(posedge clk); #1;
        char_ack = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        char_ack = 1'b1;
        while (exp_q.size() > 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        char_ack = 1'b0;
        check("drain_remaining", exp_q.size(), 0);
        check("empty_after_drain", int'(char_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_valid"}, int'(char_valid), 0);
        check({tag, "_char_out"},   int'(char_out),   0);
        check({tag, "_in_ready"},   int'(in_ready),   1);
        check({tag, "_overrun"},    int'(overrun),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; update = 1'b0; serial_in = 2'b00; char_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Leading word end after reset emits nothing
        sym(2'b10);
        idle(2);
        check("leading_space_valid", int'(char_valid), 0);
        check("leading_space_ready", int'(in_ready), 1);

        // A: visible the cycle after the character-end edge
        pattern(".-");
        exp_q.push_back(1);
        sym(2'b11);
        check("A_valid", int'(char_valid), 1);
        check("A_code", int'(char_out), 1);
        drain();
        check("A_popped_out", int'(char_out), 0);

        // Digit, letter, invalid pattern
        pattern("..---"); sym(2'b11); exp_q.push_back(29);
        pattern("-.--");  sym(2'b11); exp_q.push_back(25);
        pattern(".-.-");  sym(2'b11); exp_q.push_back(63);
        drain();

        // Overlong character, then normal decode
        pattern("------"); sym(2'b11); exp_q.push_back(63);
        pattern("-..");    sym(2'b11); exp_q.push_back(4);
        drain();

        // E, T + word end, repeated word ends: exactly one space
        pattern("."); sym(2'b11); exp_q.push_back(5);
        pattern("-"); sym(2'b10); exp_q.push_back(20);
        check("space_pend_ready_low", int'(in_ready), 0);
        idle(1);
        check("space_written_ready", int'(in_ready), 1);
        exp_q.push_back(37);
        sym(2'b10);
        sym(2'b10);
        idle(2);
        drain();

        // Fill the FIFO with four E
        for (int i = 0; i < 4; i++) begin
            pattern("."); sym(2'b11); exp_q.push_back(5);
        end
        check("full_ready", int'(in_ready), 0);
        check("pre_overrun", int'(overrun), 0);
        sym(2'b00);
        check("overrun_set", int'(overrun), 1);
        ack_one();
        check("ready_after_pop", int'(in_ready), 1);
        ack_one();
        // Occupancy 2: simultaneous push and pop
        pattern(".");
        exp_q.push_back(5);
        sym_ack(2'b11);
        pattern("."); sym(2'b11); exp_q.push_back(5);
        check("occ3_ready", int'(in_ready), 1);
        pattern("."); sym(2'b11); exp_q.push_back(5);
        check("occ4_ready", int'(in_ready), 0);
        drain();
        check("overrun_sticky", int'(overrun), 1);

        // Reset mid-character with two buffered entries
        pattern("."); sym(2'b11);
        pattern("-"); sym(2'b11);
        pattern("-..");
        check("pre_reset_valid", int'(char_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midreset");
        sym(2'b10);
        idle(2);
        check("post_reset_no_space", int'(char_valid), 0);
        pattern(".-"); sym(2'b11); exp_q.push_back(1);
        check("post_reset_code", int'(char_out), 1);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
